// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and widths for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_RUN,
        DIV_FIX
    } state_e;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? DATA_W'(~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Execute/decode-facing bundle of the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if;
    import muldiv_pkg::*;

    logic              start;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] rs_value;
    logic [DATA_W-1:0] rt_value;
    logic              mf_req;
    logic              busy;
    logic              hilo_stall;
    logic [DATA_W-1:0] reg_hi;
    logic [DATA_W-1:0] reg_lo;

    modport master (
        output start, op, rs_value, rt_value, mf_req,
        input  busy, hilo_stall, reg_hi, reg_lo
    );

    modport slave (
        input  start, op, rs_value, rt_value, mf_req,
        output busy, hilo_stall, reg_hi, reg_lo
    );

endinterface

// File: rtl/div_step.sv
// One restoring radix-2 divide iteration on unsigned magnitudes.
module div_step
    import muldiv_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] trial;

    assign shifted  = {rem, dvd_bit};
    // Only kept when shifted >= divisor, so the true difference fits in DATA_W bits.
    assign trial    = shifted[DATA_W-1:0] - divisor;
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? trial : shifted[DATA_W-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/DIV unit owning architectural HI/LO, with decode stall on MFHI/MFLO.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    hilo_muldiv_unit_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] rem_q, rem_d, dq_q, dq_d, dvs_q, dvs_d;
    logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    logic              signed_mul, signed_div;
    logic [PROD_W-1:0] mul_a, mul_b, product;
    logic [DATA_W-1:0] step_rem;
    logic              step_q;

    // Sign-extend (MULT) or zero-extend (MULTU); low 64 bits of the product are exact either way.
    assign signed_mul = (bus.op == OP_MULT);
    assign signed_div = (bus.op == OP_DIV);
    assign mul_a      = {{DATA_W{signed_mul & bus.rs_value[DATA_W-1]}}, bus.rs_value};
    assign mul_b      = {{DATA_W{signed_mul & bus.rt_value[DATA_W-1]}}, bus.rt_value};
    assign product    = mul_a * mul_b;

    // dq_q shifts dividend bits out of the top and quotient bits in at the bottom.
    div_step u_div_step (
        .rem      (rem_q),
        .dvd_bit  (dq_q[DATA_W-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            prod_d  = product;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            dq_d    = apply_sign(bus.rs_value, signed_div & bus.rs_value[DATA_W-1]);
                            dvs_d   = apply_sign(bus.rt_value, signed_div & bus.rt_value[DATA_W-1]);
                            r_neg_d = signed_div & bus.rs_value[DATA_W-1];
                            // Divide by zero keeps the all-ones quotient unsigned.
                            q_neg_d = signed_div & (bus.rs_value[DATA_W-1] ^ bus.rt_value[DATA_W-1])
                                      & (bus.rt_value != '0);
                            rem_d   = '0;
                            cnt_d   = CNT_W'(DATA_W - 1);
                            state_d = DIV_RUN;
                        end
                        OP_MTHI: hi_d = bus.rs_value;
                        OP_MTLO: lo_d = bus.rs_value;
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                if (cnt_q == '0) begin
                    hi_d    = prod_q[PROD_W-1:DATA_W];
                    lo_d    = prod_q[DATA_W-1:0];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                dq_d  = {dq_q[DATA_W-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_FIX: begin
                lo_d    = apply_sign(dq_q, q_neg_q);
                hi_d    = apply_sign(rem_q, r_neg_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.hilo_stall = bus.busy & bus.mf_req;
    assign bus.reg_hi     = hi_q;
    assign bus.reg_lo     = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: vector table through a scoreboard plus hand-built corner sequences.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if bus ();

    hilo_muldiv_unit #(.MULT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    localparam int NVEC = 13;
    vec_t        vecs [NVEC];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one op, wait (bounded) for busy to drop, then compare against the scoreboard head.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int cycles);
        exp_t e;
        int   n = 0;
        int   stalls = 0;
        logic held = 1'b1;
        sb.push_back('{exp_hi, exp_lo, cycles});
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.rs_value = rs;
        bus.rt_value = rt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (bus.busy && n < 100) begin
            if (bus.hilo_stall) stalls++;
            if (bus.reg_hi !== model_hi || bus.reg_lo !== model_lo) held = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        check({name, " busy_cycles"}, 32'(n), 32'(e.cycles));
        check({name, " stall_cycles"}, 32'(stalls), bus.mf_req ? 32'(e.cycles) : 32'd0);
        check({name, " stall_after"}, {31'b0, bus.hilo_stall}, 32'd0);
        check({name, " hold"}, {31'b0, held}, 32'd1);
        check({name, " hi"}, bus.reg_hi, e.hi);
        check({name, " lo"}, bus.reg_lo, e.lo);
        model_hi = e.hi;
        model_lo = e.lo;
    endtask

    initial begin
        int n;
        vecs[0]  = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00000000, 0};
        vecs[1]  = '{OP_MTLO,  32'h12345678, 32'h0,        32'hDEADBEEF, 32'h12345678, 0};
        vecs[2]  = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 4};
        vecs[3]  = '{OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 4};
        vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[6]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
        vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 33};
        vecs[10] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 4};
        vecs[11] = '{3'd6,     32'hCAFEF00D, 32'h1,        32'h3FFFFFFF, 32'h00000001, 0};
        vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = '0;
        bus.rs_value = '0;
        bus.rt_value = '0;
        bus.mf_req   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",  {31'b0, bus.busy}, 32'd0);
        check("reset stall", {31'b0, bus.hilo_stall}, 32'd0);
        check("reset hi", bus.reg_hi, 32'd0);
        check("reset lo", bus.reg_lo, 32'd0);
        bus.mf_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].hi, vecs[i].lo, vecs[i].cycles);
        end

        // MFHI/MFLO held in decode across a whole divide.
        bus.mf_req = 1'b1;
        run_op("stall_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        bus.mf_req = 1'b0;

        // MTHI held on start during a MULT is ignored, then taken right after busy drops.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = OP_MULT;
        bus.rs_value = 32'd3;
        bus.rt_value = 32'd5;
        @(posedge clk); #1;
        bus.op       = OP_MTHI;
        bus.rs_value = 32'hAAAA5555;
        n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("mthi_mid_mul cycles", 32'(n), 32'd4);
        check("mthi_mid_mul hi", bus.reg_hi, 32'd0);
        check("mthi_mid_mul lo", bus.reg_lo, 32'd15);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("mthi_after hi", bus.reg_hi, 32'hAAAA5555);
        check("mthi_after lo", bus.reg_lo, 32'd15);
        check("mthi_after busy", {31'b0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of a DIVU.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = OP_DIVU;
        bus.rs_value = 32'd1000;
        bus.rt_value = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("rst_mid_div busy_before", {31'b0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_div busy", {31'b0, bus.busy}, 32'd0);
        check("rst_mid_div hi", bus.reg_hi, 32'd0);
        check("rst_mid_div lo", bus.reg_lo, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_hi = '0;
        model_lo = '0;
        run_op("mtlo_after_rst", OP_MTLO, 32'h1234, 32'h0, 32'h0, 32'h1234, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
